// File: rtl/axis_i2s_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : axis_i2s_tx_if                                         |
// | Description : AXI-Stream sample bus feeding the I2S transmitter.     |
// |               Carries one stereo word per beat, last marks right.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface axis_i2s_tx_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (output data, output valid, output last, input  ready);
  modport slave  (input  data, input  valid, input  last, output ready);
endinterface
`default_nettype wire

// File: rtl/axis_i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : axis_i2s_tx                                            |
// | Description : Serialises 2-word AXI-Stream stereo pairs onto a       |
// |               Philips-I2S DAC link. SCLK = clk/4, LRCK = clk/256.     |
// |               One-pair buffer, underrun counter, sequence error.     |
// | Option      : I2S_TX_HOLD_ON_UNDERRUN_EN - repeat last pair on       |
// |               underrun instead of playing silence.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module axis_i2s_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  wire logic                 clk,
  input  wire logic                 resetn,
  axis_i2s_tx_if.slave              s_axis,
  output logic                      i2s_sclk,
  output logic                      i2s_lrck,
  output logic                      i2s_sdata,
  output logic [CNT_WIDTH-1:0]      underrun_cnt,
  output logic                      seq_err
);

  localparam logic [4:0] c_DW5 = 5'(DATA_WIDTH);

  // frame timing
  logic [7:0]            cnt_q, cnt_d;
  logic                  sclk_q, lrck_q, sdata_q, sdata_d;

  // input side
  logic                  ready_q;
  logic                  have_left_q, have_left_d;
  logic                  pair_full_q, pair_full_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;

  // frame registers being shifted out
  logic [DATA_WIDTH-1:0] frame_l_q, frame_l_d;
  logic [DATA_WIDTH-1:0] frame_r_q, frame_r_d;

  // status
  logic [CNT_WIDTH-1:0]  ucnt_q, ucnt_d;
  logic                  seq_err_q, seq_err_d;

  logic                  w_accept;
  logic                  w_wrap;
  logic [4:0]            w_k;
  logic [4:0]            w_idx;
  logic [DATA_WIDTH-1:0] w_slot;
  logic [31:0]           w_slot32;

  // State register: all flops clear immediately on reset, aborting any frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= 8'd0;
      sclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      sdata_q     <= 1'b0;
      ready_q     <= 1'b0;
      have_left_q <= 1'b0;
      pair_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      frame_l_q   <= '0;
      frame_r_q   <= '0;
      ucnt_q      <= '0;
      seq_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sclk_q      <= cnt_d[1];
      lrck_q      <= cnt_d[7];
      sdata_q     <= sdata_d;
      ready_q     <= ~pair_full_d;
      have_left_q <= have_left_d;
      pair_full_q <= pair_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      frame_l_q   <= frame_l_d;
      frame_r_q   <= frame_r_d;
      ucnt_q      <= ucnt_d;
      seq_err_q   <= seq_err_d;
    end
  end

  // Next state: frame load at wrap (uses pre-edge buffer), then word accept.
  always_comb begin
    cnt_d       = cnt_q + 8'd1;
    w_wrap      = (cnt_q == 8'hFF);
    w_accept    = s_axis.valid & ready_q;
    have_left_d = have_left_q;
    pair_full_d = pair_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    frame_l_d   = frame_l_q;
    frame_r_d   = frame_r_q;
    ucnt_d      = ucnt_q;
    seq_err_d   = 1'b0;

    if (w_wrap) begin
      if (pair_full_q) begin
        frame_l_d   = hold_l_q;
        frame_r_d   = hold_r_q;
        pair_full_d = 1'b0;
      end else begin
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
        // keep previous frame registers so the last pair repeats
        frame_l_d = frame_l_q;
        frame_r_d = frame_r_q;
`else
        frame_l_d = '0;
        frame_r_d = '0;
`endif
        if (ucnt_q != {CNT_WIDTH{1'b1}}) begin
          ucnt_d = ucnt_q + CNT_WIDTH'(1);
        end
      end
    end

    // accept only happens with pair_full_q == 0, so it never races the load
    if (w_accept) begin
      if (!s_axis.last) begin
        hold_l_d    = s_axis.data;
        have_left_d = 1'b1;
      end else if (have_left_q) begin
        hold_r_d    = s_axis.data;
        pair_full_d = 1'b1;
        have_left_d = 1'b0;
      end else begin
        seq_err_d = 1'b1;
      end
    end
  end

  // Serial bit for the upcoming cnt: one-bit I2S delay, MSB first, zero pad.
  always_comb begin
    w_k      = cnt_d[6:2];
    w_slot   = cnt_d[7] ? frame_r_q : frame_l_q;
    w_slot32 = {{(32-DATA_WIDTH){1'b0}}, w_slot};
    w_idx    = c_DW5 - w_k;
    sdata_d  = 1'b0;
    if ((w_k != 5'd0) && (w_k <= c_DW5)) begin
      sdata_d = w_slot32[w_idx];
    end
  end

  assign s_axis.ready = ready_q;
  assign i2s_sclk     = sclk_q;
  assign i2s_lrck     = lrck_q;
  assign i2s_sdata    = sdata_q;
  assign underrun_cnt = ucnt_q;
  assign seq_err      = seq_err_q;

endmodule
`default_nettype wire
